// File: rtl/segment_decoder.sv
// Recovers a 4-digit BCD score by watching a multiplexed active-low 7-segment display bus.
// Each digit must be stable for STABLE_CYCLES synchronized cycles before it is sampled; a frame publishes once all four digits are seen.
module segment_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  anode,
    input  logic [6:0]  cathode,
    output logic [15:0] score,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        pattern_err
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_HELD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);

    logic [3:0]  r_an_meta;
    logic [3:0]  r_an_sync;
    logic [6:0]  r_cat_meta;
    logic [6:0]  r_cat_sync;
    logic [10:0] r_prev;
    logic [7:0]  r_cnt;
    state_t      r_state;

    logic [15:0] r_score;
    logic        r_frame_valid;
    logic        r_frame_err;
    logic        r_pattern_err;

    logic [15:0] r_stage;
    logic [3:0]  r_seen;
    logic [3:0]  r_bad;

    logic [10:0] w_now;
    logic        w_changed;
    logic        w_sample;
    logic        w_one_low;
    logic        w_take;
    logic        w_legal;
    logic [3:0]  w_digit;
    logic [3:0]  w_hit;
    logic [3:0]  w_seen_next;
    logic [3:0]  w_bad_next;
    logic [15:0] w_stage_next;
    logic        w_complete;

    // Both buses share one synchronizer chain; no use of the raw pins anywhere else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an_meta  <= 4'b1111;
            r_an_sync  <= 4'b1111;
            r_cat_meta <= 7'b1111111;
            r_cat_sync <= 7'b1111111;
        end else begin
            r_an_meta  <= anode;
            r_an_sync  <= r_an_meta;
            r_cat_meta <= cathode;
            r_cat_sync <= r_cat_meta;
        end
    end

    assign w_now     = {r_an_sync, r_cat_sync};
    assign w_changed = (w_now != r_prev);
    assign w_sample  = (r_state == ST_WAIT) && !w_changed && (r_cnt == CNT_ARM);
    assign w_take    = w_sample && w_one_low;

    always_comb begin
        w_one_low = 1'b0;
        case (r_an_sync)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_one_low = 1'b1;
            default:                            w_one_low = 1'b0;
        endcase
    end

    always_comb begin
        w_legal = 1'b1;
        w_digit = 4'd0;
        case (r_cat_sync)
            7'b0000001: w_digit = 4'd0;
            7'b1001111: w_digit = 4'd1;
            7'b0010010: w_digit = 4'd2;
            7'b0000110: w_digit = 4'd3;
            7'b1001100: w_digit = 4'd4;
            7'b0100100: w_digit = 4'd5;
            7'b0100000: w_digit = 4'd6;
            7'b0001111: w_digit = 4'd7;
            7'b0000000: w_digit = 4'd8;
            7'b0000100: w_digit = 4'd9;
            default:    w_legal = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign w_hit[gi]       = w_take & ~r_an_sync[gi];
            assign w_seen_next[gi] = r_seen[gi] | w_hit[gi];
            assign w_bad_next[gi]  = w_hit[gi] ? ~w_legal : r_bad[gi];
            assign w_stage_next[4*gi +: 4] = (w_hit[gi] && w_legal) ? w_digit : r_stage[4*gi +: 4];

            // Staged digits survive a commit so an unchanged slot keeps its last value.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stage[4*gi +: 4] <= 4'd0;
                    r_seen[gi]         <= 1'b0;
                    r_bad[gi]          <= 1'b0;
                end else if (r_state == ST_COMMIT) begin
                    r_seen[gi] <= 1'b0;
                    r_bad[gi]  <= 1'b0;
                end else begin
                    r_stage[4*gi +: 4] <= w_stage_next[4*gi +: 4];
                    r_seen[gi]         <= w_seen_next[gi];
                    r_bad[gi]          <= w_bad_next[gi];
                end
            end
        end
    endgenerate

    assign w_complete = w_take && (&w_seen_next);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_WAIT;
            r_cnt         <= 8'd0;
            r_prev        <= 11'h7FF;
            r_score       <= 16'h0000;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_pattern_err <= 1'b0;
        end else begin
            r_prev        <= w_now;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_pattern_err <= 1'b0;
            if (w_changed) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end
            case (r_state)
                ST_WAIT: begin
                    if (w_sample) begin
                        if (w_complete) begin
                            // An illegal completing digit is reported by frame_err alone so the pulses stay exclusive.
                            r_state <= ST_COMMIT;
                            if (|w_bad_next) begin
                                r_frame_err <= 1'b1;
                            end else begin
                                r_score       <= w_stage_next;
                                r_frame_valid <= 1'b1;
                            end
                        end else begin
                            r_state       <= ST_HELD;
                            r_pattern_err <= w_take & ~w_legal;
                        end
                    end
                end
                ST_HELD: begin
                    if (w_changed) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_WAIT;
                end
                default: begin
                    r_state <= ST_WAIT;
                end
            endcase
        end
    end

    assign score       = r_score;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign pattern_err = r_pattern_err;

endmodule
